// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// E-stage forwarding select for one source operand; M has priority over W, x0 never forwarded.
module forward_unit
    import hazard_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rd_m,
    input  logic [WIDTH-1:0] rd_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    output logic [1:0]       fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            fwd = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch redirect bubbles, data-memory waits,
// E-stage forwarding and saturating performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned WIDTH            = 5,
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned CNT_WIDTH        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     Rs1D,
    input  logic [WIDTH-1:0]     Rs2D,
    input  logic [WIDTH-1:0]     Rs1E,
    input  logic [WIDTH-1:0]     Rs2E,
    input  logic [WIDTH-1:0]     RdE,
    input  logic [WIDTH-1:0]     RdM,
    input  logic [WIDTH-1:0]     RdW,
    input  logic                 MemReadE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic [CNT_WIDTH-1:0] StallCycles,
    output logic [CNT_WIDTH-1:0] FlushEvents
);

    localparam logic [2:0] BubReload = 3'(REDIRECT_BUBBLES - 1);

    state_t               state_q, state_d;
    state_t               saved_q, saved_d;
    state_t               eff_state;
    logic [2:0]           bub_q, bub_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q, flush_events_q;
    logic                 redirect_taken;
    logic                 mem_wait, load_use;
    logic [1:0]           fwd_a, fwd_b;

    forward_unit #(.WIDTH(WIDTH)) u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_a)
    );

    forward_unit #(.WIDTH(WIDTH)) u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_b)
    );

    assign ForwardAE = rst_n ? fwd_a : FWD_RF;
    assign ForwardBE = rst_n ? fwd_b : FWD_RF;

    assign mem_wait = MemReqM & ~MemReadyM;
    assign load_use = MemReadE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));

    // The cycle MEM_WAIT releases behaves exactly like the state it interrupted.
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    always_comb begin
        StallF         = 1'b0;
        StallD         = 1'b0;
        StallE         = 1'b0;
        StallM         = 1'b0;
        FlushD         = 1'b0;
        FlushE         = 1'b0;
        FlushW         = 1'b0;
        redirect_taken = 1'b0;
        state_d        = state_q;
        saved_d        = saved_q;
        bub_d          = bub_q;

        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (mem_wait) begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            StallE  = 1'b1;
            StallM  = 1'b1;
            FlushW  = 1'b1;
            state_d = MEM_WAIT;
            saved_d = eff_state;
        end else begin
            state_d = eff_state;
            if (PCSrcE) begin
                FlushD         = 1'b1;
                FlushE         = 1'b1;
                redirect_taken = 1'b1;
                if (REDIRECT_BUBBLES > 1) begin
                    bub_d   = BubReload;
                    state_d = REDIRECT;
                end else begin
                    state_d = RUN;
                end
            end else if (eff_state == REDIRECT) begin
                FlushD = 1'b1;
                if (bub_q <= 3'd1) begin
                    bub_d   = 3'd0;
                    state_d = RUN;
                end else begin
                    bub_d = bub_q - 3'd1;
                end
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= RUN;
            saved_q        <= RUN;
            bub_q          <= 3'd0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            bub_q   <= bub_d;
            if (StallF && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + CNT_WIDTH'(1);
            end
            if (redirect_taken && (flush_events_q != '1)) begin
                flush_events_q <= flush_events_q + CNT_WIDTH'(1);
            end
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushEvents = flush_events_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a cycle-level reference model queues expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    localparam int W    = 5;
    localparam int RB   = 3;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [W-1:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          MemReadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] StallCycles, FlushEvents;

    hazard_ctrl #(
        .WIDTH            (W),
        .REDIRECT_BUBBLES (RB),
        .CNT_WIDTH        (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .MemReadE    (MemReadE),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .PCSrcE      (PCSrcE),
        .MemReqM     (MemReqM),
        .MemReadyM   (MemReadyM),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushW      (FlushW),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallCycles (StallCycles),
        .FlushEvents (FlushEvents)
    );

    typedef struct {
        string         tag;
        logic [6:0]    ctl;   // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic [CW-1:0] sc;
        logic [CW-1:0] fev;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: remaining FlushD-only cycles and the two event counts.
    int m_rem = 0;
    int m_sc  = 0;
    int m_fev = 0;

    function automatic logic [1:0] ref_fwd(input logic [W-1:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic step(input string tag);
        exp_t e;
        logic sf, sd, se, sm, fd, fe, fw, mw, lu;
        {sf, sd, se, sm, fd, fe, fw} = 7'b0;
        e.tag = tag;
        e.sc  = CW'(m_sc);
        e.fev = CW'(m_fev);
        e.fa  = 2'b00;
        e.fb  = 2'b00;
        mw = MemReqM && !MemReadyM;
        lu = MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        if (!rst_n) begin
            fd = 1'b1;
            fe = 1'b1;
            m_rem = 0;
            m_sc  = 0;
            m_fev = 0;
        end else begin
            e.fa = ref_fwd(Rs1E);
            e.fb = ref_fwd(Rs2E);
            if (mw) begin
                {sf, sd, se, sm, fw} = 5'b11111;
            end else if (PCSrcE) begin
                fd = 1'b1;
                fe = 1'b1;
                m_rem = RB - 1;
                if (m_fev < CMAX) m_fev++;
            end else if (m_rem > 0) begin
                fd = 1'b1;
                m_rem--;
            end else if (lu) begin
                sf = 1'b1;
                sd = 1'b1;
                fe = 1'b1;
            end
            if (sf && m_sc < CMAX) m_sc++;
        end
        e.ctl = {sf, sd, se, sm, fd, fe, fw};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1;
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {MemReadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} = 6'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step("reset");
        step("reset");
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks += 5;
            if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl{sF,sD,sE,sM,fD,fE,fW} got %b want %b @%0t", e.tag,
                         {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, e.ctl, $time);
            end
            if (ForwardAE !== e.fa) begin
                errors++;
                $display("FAIL %s ForwardAE got %b want %b @%0t", e.tag, ForwardAE, e.fa, $time);
            end
            if (ForwardBE !== e.fb) begin
                errors++;
                $display("FAIL %s ForwardBE got %b want %b @%0t", e.tag, ForwardBE, e.fb, $time);
            end
            if (StallCycles !== e.sc) begin
                errors++;
                $display("FAIL %s StallCycles got %0d want %0d @%0t", e.tag, StallCycles, e.sc,
                         $time);
            end
            if (FlushEvents !== e.fev) begin
                errors++;
                $display("FAIL %s FlushEvents got %0d want %0d @%0t", e.tag, FlushEvents, e.fev,
                         $time);
            end
        end
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Forwarding priority and x0 suppression
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        step("fwd_mem");
        RdM = 0;
        step("fwd_wb");
        Rs2E = 0; RdW = 0;
        step("fwd_x0");
        idle_inputs();

        // Load-use: one stall cycle, then the load has moved on
        MemReadE = 1; RdE = 7; Rs2D = 7;
        step("loaduse");
        MemReadE = 0; RdE = 0;
        step("loaduse_done");
        MemReadE = 1; RdE = 0; Rs2D = 0;
        step("loaduse_x0");
        idle_inputs();

        // Redirect with a simultaneous load-use that must be ignored
        MemReadE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
        step("redir0");
        PCSrcE = 0;
        step("redir1");
        step("redir2");
        idle_inputs();
        step("redir3");

        // Memory wait: four stall cycles then release
        do_reset();
        MemReqM = 1;
        repeat (4) step("memwait");
        MemReadyM = 1;
        step("mem_release");
        MemReqM = 0; MemReadyM = 0;
        step("mem_after");

        // Memory wait inside a redirect freezes the bubble count
        PCSrcE = 1;
        step("redir_w0");
        PCSrcE = 0; MemReqM = 1;
        repeat (3) step("redir_wait");
        MemReadyM = 1;
        step("redir_wrel");
        MemReqM = 0; MemReadyM = 0;
        repeat (3) step("redir_wafter");

        // Saturation of the stall counter, then reset in the middle of a wait
        MemReqM = 1;
        repeat (CMAX + 5) step("sat");
        rst_n = 0;
        repeat (2) step("rst_in_wait");
        idle_inputs();
        repeat (2) step("post_rst");

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst_n     = ($urandom_range(0, 149) != 0);
            Rs1D      = W'($urandom_range(0, 3));
            Rs2D      = W'($urandom_range(0, 3));
            Rs1E      = W'($urandom_range(0, 3));
            Rs2E      = W'($urandom_range(0, 3));
            RdE       = W'($urandom_range(0, 3));
            RdM       = W'($urandom_range(0, 3));
            RdW       = W'($urandom_range(0, 3));
            MemReadE  = ($urandom_range(0, 2) == 0);
            RegWriteM = ($urandom_range(0, 1) == 0);
            RegWriteW = ($urandom_range(0, 1) == 0);
            PCSrcE    = ($urandom_range(0, 7) == 0);
            MemReqM   = ($urandom_range(0, 3) == 0);
            MemReadyM = ($urandom_range(0, 2) != 0);
            step("random");
        end

        idle_inputs();
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain scoreboard entries left %0d want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
